// File: rtl/mult_div_pkg.sv
// Shared encodings for the multiply/divide unit and the control unit that issues MULT/DIV.
package mult_div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring on magnitudes) unit.
// One iteration per cycle for WIDTH cycles; hi/lo and a 1-cycle done are written in FIN.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_q, op_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic               q1_q, q1_d;
  logic [WIDTH:0]     mcand_q, mcand_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH:0]     a_ext, b_ext, a_mag, b_mag;
  logic [WIDTH:0]     booth_sum, rem_sh, rem_trial;
  logic [WIDTH-1:0]   rem_lo;

  // Magnitudes are one bit wider so that the most negative operand survives negation.
  assign a_ext = {a[WIDTH-1], a};
  assign b_ext = {b[WIDTH-1], b};
  assign a_mag = a[WIDTH-1] ? ('0 - a_ext) : a_ext;
  assign b_mag = b[WIDTH-1] ? ('0 - b_ext) : b_ext;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    acc_d    = acc_q;
    m_d      = m_q;
    q1_d     = q1_q;
    mcand_d  = mcand_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dz_d     = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case ({m_q[0], q1_q})
      2'b01:   booth_sum = acc_q + mcand_q;
      2'b10:   booth_sum = acc_q - mcand_q;
      default: booth_sum = acc_q;
    endcase
    rem_sh    = {acc_q[WIDTH-1:0], m_q[WIDTH-1]};
    rem_trial = rem_sh - mcand_q;
    rem_lo    = acc_q[WIDTH-1:0];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == OP_DIV && b == '0) begin
            dz_d = 1'b1;
          end else begin
            state_d  = S_CALC;
            busy_d   = 1'b1;
            cnt_d    = '0;
            op_d     = op;
            sign_a_d = a[WIDTH-1];
            sign_b_d = b[WIDTH-1];
            q1_d     = 1'b0;
            if (op == OP_MULT) begin
              acc_d   = '0;
              m_d     = b;
              mcand_d = a_ext;
            end else begin
              // Remainder in acc, dividend magnitude shifts out of m as quotient bits shift in.
              {acc_d, m_d} = {{WIDTH{1'b0}}, a_mag};
              mcand_d      = b_mag;
            end
          end
        end
      end
      S_CALC: begin
        if (op_q == OP_MULT) begin
          {acc_d, m_d, q1_d} = {booth_sum[WIDTH], booth_sum, m_q};
        end else if (rem_sh >= mcand_q) begin
          acc_d = rem_trial;
          m_d   = {m_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = rem_sh;
          m_d   = {m_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (op_q == OP_MULT) begin
          hi_d = rem_lo;
          lo_d = m_q;
        end else begin
          hi_d = sign_a_q ? ('0 - rem_lo) : rem_lo;
          lo_d = (sign_a_q ^ sign_b_q) ? ('0 - m_q) : m_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MULT;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      acc_q    <= '0;
      m_q      <= '0;
      q1_q     <= 1'b0;
      mcand_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      acc_q    <= acc_d;
      m_q      <= m_d;
      q1_q     <= q1_d;
      mcand_q  <= mcand_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table plus scoreboard, and hand sequences
// for divide-by-zero, ignored starts and reset during an operation.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  res_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Pop the scoreboard head and compare it with the outputs presented alongside done.
  task automatic score(input string tag);
    res_t r;
    if (sb_q.size() == 0) begin
      check({tag, "/unexpected_done"}, 64'd1, 64'd0);
    end else begin
      r = sb_q.pop_front();
      check({tag, "/hi"}, hi, r.hi);
      check({tag, "/lo"}, lo, r.lo);
    end
  endtask

  task automatic do_op(input logic o, input logic [31:0] xa, input logic [31:0] xb,
                       input logic [31:0] eh, input logic [31:0] el, input string tag);
    int cyc;
    sb_q.push_back('{eh, el});
    @(negedge clk);
    start = 1'b1; op = o; a = xa; b = xb;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    check({tag, "/busy"}, busy, 1);
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "/latency"}, cyc, 33);
    if (done) begin
      score(tag);
      check({tag, "/dz_at_done"}, div_zero, 0);
    end else begin
      void'(sb_q.pop_front());
    end
    @(negedge clk);
    check({tag, "/done_pulse"}, done, 0);
    check({tag, "/busy_after"}, busy, 0);
  endtask

  vec_t vecs[14];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int   cyc;
    int   ndone;
    bit   dz_seen;
    logic [31:0] xa, xb, eh, el;
    logic [63:0] p;
    longint sa, sb2, q, r;
    logic o;

    vecs[0]  = '{1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1]  = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[2]  = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[4]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[6]  = '{1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
    vecs[7]  = '{1'b1, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[8]  = '{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd14};
    vecs[9]  = '{1'b1, 32'd3,         32'd5,         32'd3,         32'd0};
    vecs[10] = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[11] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0001};
    vecs[12] = '{1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000};
    vecs[13] = '{1'b0, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000};

    // Reset state
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset/busy", busy, 0);
    check("reset/done", done, 0);
    check("reset/div_zero", div_zero, 0);
    check("reset/hi", hi, 0);
    check("reset/lo", lo, 0);
    reset = 1'b1;

    foreach (vecs[i])
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));

    // Random operands against a behavioural 64-bit model
    for (int i = 0; i < 16; i++) begin
      o  = i[0];
      xa = $urandom;
      xb = (i % 4 == 3) ? (32'($urandom_range(1, 20)) ^ {32{xa[0]}}) : $urandom;
      if (o && xb == 32'd0) xb = 32'd1;
      sa  = longint'($signed(xa));
      sb2 = longint'($signed(xb));
      if (o == 1'b0) begin
        p  = 64'(sa * sb2);
        eh = p[63:32];
        el = p[31:0];
      end else begin
        q  = sa / sb2;
        r  = sa % sb2;
        el = q[31:0];
        eh = r[31:0];
      end
      do_op(o, xa, xb, eh, el, $sformatf("rnd%0d", i));
    end

    // Divide by zero leaves hi/lo alone and only pulses div_zero
    do_op(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, "pre_dz");
    @(negedge clk);
    start = 1'b1; op = 1'b1; a = 32'd5; b = 32'd0;
    @(negedge clk);
    start = 1'b0;
    check("dz/flag", div_zero, 1);
    check("dz/busy", busy, 0);
    check("dz/done", done, 0);
    check("dz/hi", hi, 32'd2);
    check("dz/lo", lo, 32'd14);
    @(negedge clk);
    check("dz/flag_pulse", div_zero, 0);
    ndone = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("dz/no_activity", ndone, 0);

    // Starts while busy are ignored; a start right after done is accepted
    sb_q.push_back('{32'd0, 32'd12});
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    dz_seen = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      dz_seen |= div_zero;
      start = (cyc == 5 || cyc == 20);
      if (cyc == 5)  begin op = 1'b1; a = 32'd9;   b = 32'd0;   end
      if (cyc == 20) begin op = 1'b0; a = 32'd100; b = 32'd100; end
    end
    start = 1'b0;
    check("ign/latency", cyc, 33);
    check("ign/no_dz", dz_seen, 0);
    if (done) score("ign");
    sb_q.push_back('{32'd0, 32'd30});
    start = 1'b1; op = 1'b0; a = 32'd5; b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    check("b2b/busy", busy, 1);
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b/latency", cyc, 33);
    if (done) score("b2b");
    else void'(sb_q.pop_front());

    // Reset in the middle of a divide discards the result
    @(negedge clk);
    start = 1'b1; op = 1'b1; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid/busy", busy, 0);
    check("rst_mid/hi", hi, 0);
    check("rst_mid/lo", lo, 0);
    check("rst_mid/done", done, 0);
    reset = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("rst_mid/no_done", ndone, 0);
    do_op(1'b0, 32'd2, 32'd2, 32'd0, 32'd4, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
